// File: rtl/tppe_pkg.sv
// Shared constants and types for the TPPE spike-fibre front end.
// Tile geometry, read-port address width and the buffer FSM state encoding.
package tppe_pkg;
   localparam int BITMASK_WIDTH = 128;
   localparam int TIMESTEPS     = 8;
   localparam int ADDR_WIDTH    = 8;
   localparam int CNT_WIDTH     = $clog2(BITMASK_WIDTH) + 1;
   localparam int POS_WIDTH     = $clog2(BITMASK_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SERVE
   } state_t;
endpackage

// File: rtl/spike_fibre_mem.sv
// Compressed spike-vector store: BITMASK_WIDTH x TIMESTEPS array, one write port, one read port.
// Latency: 1 cycle from rd_en to rd_data; rd_data holds when rd_en is low.
// Backpressure: none, every write and read is accepted in its cycle.
module spike_fibre_mem
   import tppe_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [POS_WIDTH-1:0] wr_addr,
   input  logic [TIMESTEPS-1:0] wr_data,
   input  logic                 rd_en,
   input  logic [POS_WIDTH-1:0] rd_addr,
   output logic [TIMESTEPS-1:0] rd_data
);

   logic [TIMESTEPS-1:0] mem [BITMASK_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/spike_fibre_buffer.sv
// Loads one tile of dense spike vectors, builds its occupancy mask and serves the non-zero vectors compressed.
// Latency: full tile load in BITMASK_WIDTH beats; fibre_a reads return 1 cycle after read_en.
// Backpressure: spike_in_ready is high only while loading; reads outside SERVE are dropped.
module spike_fibre_buffer
   import tppe_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tile_start,
   input  logic [TIMESTEPS-1:0]     spike_in,
   input  logic                     spike_in_valid,
   output logic                     spike_in_ready,
   input  logic                     tile_done,
   input  logic [ADDR_WIDTH-1:0]    fibre_a_addr,
   input  logic                     fibre_a_read_en,
   output logic [TIMESTEPS-1:0]     fibre_a_data,
   output logic                     fibre_a_valid,
   output logic [BITMASK_WIDTH-1:0] bitmask_a,
   output logic                     bitmask_valid,
   output logic [CNT_WIDTH-1:0]     nnz_count,
   output logic                     addr_error
);

   localparam int CMP_WIDTH = (ADDR_WIDTH > CNT_WIDTH) ? ADDR_WIDTH : CNT_WIDTH;

   state_t               state, state_next;
   logic [POS_WIDTH-1:0] pos;
   logic                 beat_acc;
   logic                 last_beat;
   logic                 rd_fire;
   logic                 in_range;
   logic                 rd_oor_q;
   logic [TIMESTEPS-1:0] mem_rd_data;

   assign spike_in_ready = (state == LOAD);
   assign bitmask_valid  = (state == SERVE);
   assign beat_acc       = spike_in_valid && spike_in_ready;
   assign last_beat      = beat_acc && (pos == POS_WIDTH'(BITMASK_WIDTH - 1));
   assign rd_fire        = fibre_a_read_en && (state == SERVE);
   assign in_range       = CMP_WIDTH'(fibre_a_addr) < CMP_WIDTH'(nnz_count);

   // Out-of-range reads present zero without disturbing the stored data.
   assign fibre_a_data   = rd_oor_q ? '0 : mem_rd_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (tile_start) state_next = LOAD;
         LOAD:    if (last_beat)  state_next = SERVE;
         SERVE:   if (tile_done)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos           <= '0;
         nnz_count     <= '0;
         bitmask_a     <= '0;
         addr_error    <= 1'b0;
         fibre_a_valid <= 1'b0;
         rd_oor_q      <= 1'b0;
      end else begin
         fibre_a_valid <= rd_fire;
         if (rd_fire) begin
            rd_oor_q <= !in_range;
            if (!in_range) addr_error <= 1'b1;
         end
         if ((state == IDLE) && tile_start) begin
            pos        <= '0;
            nnz_count  <= '0;
            bitmask_a  <= '0;
            addr_error <= 1'b0;
         end else if (beat_acc) begin
            bitmask_a[pos] <= |spike_in;
            if (spike_in != '0) nnz_count <= nnz_count + 1'b1;
            pos <= pos + 1'b1;
         end
      end
   end

   // nnz_count stays below BITMASK_WIDTH while loading, so its low bits index the store directly.
   spike_fibre_mem u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (beat_acc && (spike_in != '0)),
      .wr_addr (nnz_count[POS_WIDTH-1:0]),
      .wr_data (spike_in),
      .rd_en   (rd_fire),
      .rd_addr (fibre_a_addr[POS_WIDTH-1:0]),
      .rd_data (mem_rd_data)
   );

endmodule

// File: tb/tb_spike_fibre_buffer.sv
// Randomised self-checking bench for spike_fibre_buffer against a queue-based model of the compressed tile.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_spike_fibre_buffer;
   import tppe_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     tile_start;
   logic [TIMESTEPS-1:0]     spike_in;
   logic                     spike_in_valid;
   logic                     spike_in_ready;
   logic                     tile_done;
   logic [ADDR_WIDTH-1:0]    fibre_a_addr;
   logic                     fibre_a_read_en;
   logic [TIMESTEPS-1:0]     fibre_a_data;
   logic                     fibre_a_valid;
   logic [BITMASK_WIDTH-1:0] bitmask_a;
   logic                     bitmask_valid;
   logic [CNT_WIDTH-1:0]     nnz_count;
   logic                     addr_error;

   int n_checks = 0;
   int n_fail   = 0;

   logic [TIMESTEPS-1:0]     dense [BITMASK_WIDTH];
   logic [BITMASK_WIDTH-1:0] exp_mask;
   logic [TIMESTEPS-1:0]     exp_list [$];

   always #5 clk = ~clk;

   spike_fibre_buffer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .tile_start      (tile_start),
      .spike_in        (spike_in),
      .spike_in_valid  (spike_in_valid),
      .spike_in_ready  (spike_in_ready),
      .tile_done       (tile_done),
      .fibre_a_addr    (fibre_a_addr),
      .fibre_a_read_en (fibre_a_read_en),
      .fibre_a_data    (fibre_a_data),
      .fibre_a_valid   (fibre_a_valid),
      .bitmask_a       (bitmask_a),
      .bitmask_valid   (bitmask_valid),
      .nnz_count       (nnz_count),
      .addr_error      (addr_error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the mask marks non-zero positions, the list keeps non-zero vectors in position order.
   task automatic build_model();
      exp_mask = '0;
      exp_list.delete();
      for (int i = 0; i < BITMASK_WIDTH; i++) begin
         if (dense[i] != '0) begin
            exp_mask[i] = 1'b1;
            exp_list.push_back(dense[i]);
         end
      end
   endtask

   task automatic random_tile(input int nz_pct);
      for (int i = 0; i < BITMASK_WIDTH; i++)
         dense[i] = ($urandom_range(99) < nz_pct) ? TIMESTEPS'($urandom) : '0;
   endtask

   // Pulses tile_start, streams dense[] with optional gaps, returns edges until bitmask_valid.
   task automatic load_tile(input int gap_pct, output int edges, output bit timeout);
      int idx;
      bit acc;
      idx = 0;
      edges = 0;
      timeout = 1'b0;
      tile_start = 1'b1;
      tick();
      tile_start = 1'b0;
      while (!bitmask_valid && !timeout) begin
         if (idx < BITMASK_WIDTH) begin
            spike_in       = dense[idx];
            spike_in_valid = ($urandom_range(99) >= gap_pct);
         end else begin
            spike_in_valid = 1'b0;
         end
         acc = spike_in_valid && spike_in_ready;
         tick();
         edges++;
         if (acc) idx++;
         if (edges > 4 * BITMASK_WIDTH) timeout = 1'b1;
      end
      spike_in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tile_start = 1'b0; spike_in = '0; spike_in_valid = 1'b0; tile_done = 1'b0;
      fibre_a_addr = '0; fibre_a_read_en = 1'b0;
      tick(); tick(); tick();
      n_checks++;
      if ({bitmask_a, nnz_count, fibre_a_data, fibre_a_valid, addr_error, bitmask_valid, spike_in_ready} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: mask=%h nnz=%0d data=%h vld=%b err=%b bvld=%b rdy=%b, required all 0",
                  bitmask_a, nnz_count, fibre_a_data, fibre_a_valid, addr_error, bitmask_valid, spike_in_ready);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_dense();
      int edges;
      bit to;
      for (int i = 0; i < BITMASK_WIDTH; i++) dense[i] = '0;
      dense[3] = 8'h81; dense[10] = 8'h01; dense[127] = 8'hFF;
      build_model();
      n_checks++;
      if (spike_in_ready !== 1'b0) begin
         n_fail++; $display("FAIL ready_idle: got %b required 0", spike_in_ready);
      end
      load_tile(0, edges, to);
      n_checks++;
      if (to || edges != BITMASK_WIDTH) begin
         n_fail++; $display("FAIL dense_load_time: got %0d edges (timeout=%b) required %0d", edges, to, BITMASK_WIDTH);
      end
      n_checks++;
      if (bitmask_a !== exp_mask) begin
         n_fail++; $display("FAIL dense_mask: got %h required %h", bitmask_a, exp_mask);
      end
      n_checks++;
      if (nnz_count !== CNT_WIDTH'(exp_list.size())) begin
         n_fail++; $display("FAIL dense_nnz: got %0d required %0d", nnz_count, exp_list.size());
      end
      fibre_a_read_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         fibre_a_addr = ADDR_WIDTH'(k);
         tick();
         n_checks++;
         if (fibre_a_valid !== 1'b1 || fibre_a_data !== exp_list[k]) begin
            n_fail++; $display("FAIL dense_read%0d: got vld=%b data=%h required vld=1 data=%h", k, fibre_a_valid, fibre_a_data, exp_list[k]);
         end
      end
      fibre_a_read_en = 1'b0;
      tick();
      n_checks++;
      if (fibre_a_valid !== 1'b0 || addr_error !== 1'b0) begin
         n_fail++; $display("FAIL dense_read_end: got vld=%b err=%b required vld=0 err=0", fibre_a_valid, addr_error);
      end
   endtask

   task automatic test_out_of_range();
      logic [CNT_WIDTH-1:0] nnz_before;
      nnz_before = nnz_count;
      fibre_a_read_en = 1'b1;
      fibre_a_addr = ADDR_WIDTH'(exp_list.size());
      tick();
      fibre_a_read_en = 1'b0;
      n_checks++;
      if (fibre_a_valid !== 1'b1 || fibre_a_data !== '0 || addr_error !== 1'b1) begin
         n_fail++; $display("FAIL oor_read: got vld=%b data=%h err=%b required vld=1 data=0 err=1", fibre_a_valid, fibre_a_data, addr_error);
      end
      fibre_a_read_en = 1'b1;
      fibre_a_addr = '0;
      tick();
      fibre_a_read_en = 1'b0;
      n_checks++;
      if (fibre_a_data !== exp_list[0] || addr_error !== 1'b1) begin
         n_fail++; $display("FAIL oor_sticky: got data=%h err=%b required data=%h err=1", fibre_a_data, addr_error, exp_list[0]);
      end
      tile_done = 1'b1;
      tick();
      tile_done = 1'b0;
      n_checks++;
      if (bitmask_valid !== 1'b0 || bitmask_a !== exp_mask || nnz_count !== nnz_before || addr_error !== 1'b1) begin
         n_fail++; $display("FAIL idle_hold: got bvld=%b mask=%h nnz=%0d err=%b required bvld=0 mask=%h nnz=%0d err=1",
                            bitmask_valid, bitmask_a, nnz_count, addr_error, exp_mask, nnz_before);
      end
      tile_start = 1'b1;
      tick();
      tile_start = 1'b0;
      n_checks++;
      if (addr_error !== 1'b0 || nnz_count !== '0 || bitmask_a !== '0 || spike_in_ready !== 1'b1) begin
         n_fail++; $display("FAIL start_clears: got err=%b nnz=%0d mask=%h rdy=%b required err=0 nnz=0 mask=0 rdy=1",
                            addr_error, nnz_count, bitmask_a, spike_in_ready);
      end
   endtask

   task automatic test_ignored_controls();
      int edges;
      bit to;
      random_tile(50);
      dense[5] = 8'h5A;
      build_model();
      load_tile(0, edges, to);
      n_checks++;
      if (to || bitmask_a !== exp_mask || nnz_count !== CNT_WIDTH'(exp_list.size())) begin
         n_fail++; $display("FAIL ign_load: got to=%b mask=%h nnz=%0d required mask=%h nnz=%0d", to, bitmask_a, nnz_count, exp_mask, exp_list.size());
      end
      tile_start = 1'b1;
      tick();
      tile_start = 1'b0;
      n_checks++;
      if (bitmask_valid !== 1'b1 || spike_in_ready !== 1'b0 || nnz_count !== CNT_WIDTH'(exp_list.size())) begin
         n_fail++; $display("FAIL start_in_serve: got bvld=%b rdy=%b nnz=%0d required bvld=1 rdy=0 nnz=%0d",
                            bitmask_valid, spike_in_ready, nnz_count, exp_list.size());
      end
      fibre_a_addr = '0;
      fibre_a_read_en = 1'b1;
      tile_done = 1'b1;
      tick();
      fibre_a_read_en = 1'b0;
      tile_done = 1'b0;
      n_checks++;
      if (fibre_a_valid !== 1'b1 || fibre_a_data !== exp_list[0] || bitmask_valid !== 1'b0) begin
         n_fail++; $display("FAIL read_with_done: got vld=%b data=%h bvld=%b required vld=1 data=%h bvld=0",
                            fibre_a_valid, fibre_a_data, bitmask_valid, exp_list[0]);
      end
      fibre_a_addr = 8'd200;
      fibre_a_read_en = 1'b1;
      tick();
      tick();
      fibre_a_read_en = 1'b0;
      n_checks++;
      if (fibre_a_valid !== 1'b0 || fibre_a_data !== exp_list[0] || addr_error !== 1'b0 || spike_in_ready !== 1'b0) begin
         n_fail++; $display("FAIL read_in_idle: got vld=%b data=%h err=%b rdy=%b required vld=0 data=%h err=0 rdy=0",
                            fibre_a_valid, fibre_a_data, addr_error, spike_in_ready, exp_list[0]);
      end
   endtask

   task automatic test_gaps();
      int edges;
      bit to;
      random_tile(50);
      build_model();
      for (int pass = 0; pass < 2; pass++) begin
         load_tile(pass * 50, edges, to);
         n_checks++;
         if (to || bitmask_a !== exp_mask || nnz_count !== CNT_WIDTH'(exp_list.size())) begin
            n_fail++; $display("FAIL gaps%0d_load: got to=%b mask=%h nnz=%0d required mask=%h nnz=%0d",
                               pass, to, bitmask_a, nnz_count, exp_mask, exp_list.size());
         end
         n_checks++;
         if (spike_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL gaps%0d_ready_serve: got %b required 0", pass, spike_in_ready);
         end
         fibre_a_read_en = 1'b1;
         for (int k = 0; k < exp_list.size(); k++) begin
            fibre_a_addr = ADDR_WIDTH'(k);
            tick();
            n_checks++;
            if (fibre_a_valid !== 1'b1 || fibre_a_data !== exp_list[k]) begin
               n_fail++; $display("FAIL gaps%0d_read%0d: got vld=%b data=%h required vld=1 data=%h",
                                  pass, k, fibre_a_valid, fibre_a_data, exp_list[k]);
            end
         end
         fibre_a_read_en = 1'b0;
         tile_done = 1'b1;
         tick();
         tile_done = 1'b0;
      end
   endtask

   task automatic test_reset_mid_load();
      int edges;
      bit to;
      random_tile(60);
      tile_start = 1'b1;
      tick();
      tile_start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         spike_in = dense[i];
         spike_in_valid = 1'b1;
         tick();
      end
      spike_in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bitmask_a, nnz_count, fibre_a_data, fibre_a_valid, addr_error, bitmask_valid, spike_in_ready} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: mask=%h nnz=%0d data=%h vld=%b err=%b bvld=%b rdy=%b, required all 0",
                  bitmask_a, nnz_count, fibre_a_data, fibre_a_valid, addr_error, bitmask_valid, spike_in_ready);
      end
      tick();
      rst_n = 1'b1;
      tick();
      random_tile(40);
      build_model();
      load_tile(0, edges, to);
      n_checks++;
      if (to || edges != BITMASK_WIDTH || bitmask_a !== exp_mask || nnz_count !== CNT_WIDTH'(exp_list.size())) begin
         n_fail++; $display("FAIL fresh_load: got edges=%0d to=%b mask=%h nnz=%0d required edges=%0d mask=%h nnz=%0d",
                            edges, to, bitmask_a, nnz_count, BITMASK_WIDTH, exp_mask, exp_list.size());
      end
      fibre_a_read_en = 1'b1;
      for (int k = 0; k < exp_list.size(); k++) begin
         fibre_a_addr = ADDR_WIDTH'(k);
         tick();
         n_checks++;
         if (fibre_a_valid !== 1'b1 || fibre_a_data !== exp_list[k]) begin
            n_fail++; $display("FAIL fresh_read%0d: got vld=%b data=%h required vld=1 data=%h", k, fibre_a_valid, fibre_a_data, exp_list[k]);
         end
      end
      fibre_a_read_en = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_dense();
      test_out_of_range();
      test_ignored_controls();
      test_gaps();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
